// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - run controller: reset sequencing, free-run/single-step enable, halt/budget completion
module proc_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 15,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt,
  output logic             core_reset,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout
);

  // rst counter only needs to hold RST_CYCLES-1
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RST_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSTSEQ = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state;
  logic [RC_W-1:0] rst_cnt;
  logic            step_q;
  logic            step_rise;
  logic [CNT_W-1:0] cnt_inc;

  // step and halt act on core_en within the same cycle; start only affects state
  assign step_rise  = step & ~step_q;
  assign core_reset = (state == IDLE) | (state == RSTSEQ);
  assign core_en    = (state == RUN) & ~halt & (~step_mode | step_rise);
  assign cnt_inc    = cycle_count + CNT_W'(1);

  // step history for edge detection, tracked in every state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // run sequencing, cycle accounting and completion status
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RSTSEQ;
            rst_cnt     <= RST_LOAD;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        RSTSEQ: begin
          if (rst_cnt == '0) begin
            state <= RUN;
          end else begin
            rst_cnt <= rst_cnt - RC_W'(1);
          end
        end
        RUN: begin
          // halt gates core_en, so a halt cycle never counts and never times out
          if (halt) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (core_en) begin
            if (MAX_CYCLES == 0) begin
              if (cycle_count != CNT_SAT) begin
                cycle_count <= cnt_inc;
              end
            end else begin
              cycle_count <= cnt_inc;
              if (cnt_inc == MAX_VAL) begin
                state   <= DONE;
                done    <= 1'b1;
                timeout <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb/tb_proc_run_ctrl.sv - scoreboard bench for proc_run_ctrl (default and unlimited-budget instances)
module tb_proc_run_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0, step_mode = 1'b0, step = 1'b0, halt = 1'b0;
  logic       core_reset1, core_en1, done1, timeout1;
  logic [15:0] cycle_count1;
  logic       start2 = 1'b0, step_mode2 = 1'b0, step2 = 1'b0, halt2 = 1'b0;
  logic       core_reset2, core_en2, done2, timeout2;
  logic [7:0] cycle_count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int    cyc;
    int    dut;
    string name;
    logic  cr;
    logic  ce;
    int    cnt;
    logic  dn;
    logic  to;
  } exp_t;

  exp_t sb[$];

  proc_run_ctrl dut1 (
    .Clk(Clk), .Reset(Reset), .start(start), .step_mode(step_mode), .step(step), .halt(halt),
    .core_reset(core_reset1), .core_en(core_en1), .cycle_count(cycle_count1),
    .done(done1), .timeout(timeout1)
  );

  proc_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(0), .CNT_W(8)) dut2 (
    .Clk(Clk), .Reset(Reset), .start(start2), .step_mode(step_mode2), .step(step2), .halt(halt2),
    .core_reset(core_reset2), .core_en(core_en2), .cycle_count(cycle_count2),
    .done(done2), .timeout(timeout2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // monitor: mid-cycle sample, compare every expectation due this cycle
  logic acr, ace, adn, ato;
  int   acnt;
  always @(negedge Clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].dut == 1) begin
          acr = core_reset1; ace = core_en1; acnt = int'(cycle_count1); adn = done1; ato = timeout1;
        end else begin
          acr = core_reset2; ace = core_en2; acnt = int'(cycle_count2); adn = done2; ato = timeout2;
        end
        checks++;
        if (sb[i].cyc != cyc || acr !== sb[i].cr || ace !== sb[i].ce || acnt != sb[i].cnt ||
            adn !== sb[i].dn || ato !== sb[i].to) begin
          errors++;
          $display("FAIL %s dut%0d cyc=%0d got cr=%b ce=%b cnt=%0d done=%b to=%b want cr=%b ce=%b cnt=%0d done=%b to=%b",
                   sb[i].name, sb[i].dut, cyc, acr, ace, acnt, adn, ato,
                   sb[i].cr, sb[i].ce, sb[i].cnt, sb[i].dn, sb[i].to);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic expect_at(input int off, input int d, input string nm, input logic cr,
                           input logic ce, input int cnt, input logic dn, input logic to);
    exp_t e;
    e.cyc = cyc + off; e.dut = d; e.name = nm;
    e.cr = cr; e.ce = ce; e.cnt = cnt; e.dn = dn; e.to = to;
    sb.push_back(e);
  endtask

  // start sampled at the edge ending cycle off: 2 reset cycles, 15 enabled, then timeout
  task automatic free_run_expect(input int off);
    expect_at(off + 1, 1, "rstseq_a", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(off + 2, 1, "rstseq_b", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      expect_at(off + 3 + i, 1, "free_run", 1'b0, 1'b1, i, 1'b0, 1'b0);
    expect_at(off + 18, 1, "timeout_done", 1'b0, 1'b0, 15, 1'b1, 1'b1);
  endtask

  initial begin
    #2 Reset = 1'b1;
    tick(2);
    expect_at(0, 1, "reset_state", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(0, 2, "reset_state2", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    tick(1);
    Reset = 1'b0;
    expect_at(0, 1, "idle", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    tick(1);

    // free run to timeout, then hold
    start = 1'b1;
    free_run_expect(0);
    expect_at(19, 1, "done_hold", 1'b0, 1'b0, 15, 1'b1, 1'b1);
    tick(1);
    start = 1'b0;
    tick(19);

    // restart from DONE, halt at count 5
    start = 1'b1;
    expect_at(1, 1, "restart_clear", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(2, 1, "restart_rst", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      expect_at(3 + i, 1, "halt_run", 1'b0, 1'b1, i, 1'b0, 1'b0);
    expect_at(8, 1, "halt_cycle", 1'b0, 1'b0, 5, 1'b0, 1'b0);
    expect_at(9, 1, "halt_done", 1'b0, 1'b0, 5, 1'b1, 1'b0);
    expect_at(10, 1, "halt_hold", 1'b0, 1'b0, 5, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    tick(7);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(2);

    // single-step: three 4-high/3-low step pulses
    step_mode = 1'b1;
    start = 1'b1;
    expect_at(1, 1, "step_rst_a", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(2, 1, "step_rst_b", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 3; k <= 24; k++)
      expect_at(k, 1, "step", 1'b0, (k == 4 || k == 11 || k == 18),
                (k <= 4) ? 0 : (k <= 11) ? 1 : (k <= 18) ? 2 : 3, 1'b0, 1'b0);
    tick(1);
    start = 1'b0;
    tick(3); step = 1'b1;
    tick(4); step = 1'b0;
    tick(3); step = 1'b1;
    tick(4); step = 1'b0;
    tick(3); step = 1'b1;
    tick(4); step = 1'b0;
    tick(3);

    // switch to free run mid-RUN, async reset between edges at count 7
    step_mode = 1'b0;
    for (int k = 0; k < 4; k++)
      expect_at(k, 1, "mode_switch", 1'b0, 1'b1, 3 + k, 1'b0, 1'b0);
    expect_at(4, 1, "async_reset", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(5, 1, "reset_held", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(6, 1, "post_reset_idle", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    tick(4);
    #1 Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(1);

    // start held through RSTSEQ/RUN is ignored; still high in DONE it restarts
    start = 1'b1;
    free_run_expect(0);
    free_run_expect(18);
    tick(19);
    start = 1'b0;
    tick(18);

    // unlimited budget, 8-bit count: saturate at 255, then halt
    start2 = 1'b1;
    expect_at(1, 2, "sat_rst_a", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(2, 2, "sat_rst_b", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_at(3, 2, "sat_first", 1'b0, 1'b1, 0, 1'b0, 1'b0);
    expect_at(103, 2, "sat_100", 1'b0, 1'b1, 100, 1'b0, 1'b0);
    expect_at(257, 2, "sat_254", 1'b0, 1'b1, 254, 1'b0, 1'b0);
    expect_at(258, 2, "sat_255", 1'b0, 1'b1, 255, 1'b0, 1'b0);
    expect_at(259, 2, "sat_nowrap", 1'b0, 1'b1, 255, 1'b0, 1'b0);
    expect_at(303, 2, "sat_300", 1'b0, 1'b1, 255, 1'b0, 1'b0);
    expect_at(304, 2, "sat_halt_cycle", 1'b0, 1'b0, 255, 1'b0, 1'b0);
    expect_at(305, 2, "sat_halt_done", 1'b0, 1'b0, 255, 1'b1, 1'b0);
    tick(1);
    start2 = 1'b0;
    tick(303);
    halt2 = 1'b1;
    tick(1);
    halt2 = 1'b0;
    tick(3);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_run_ctrl.md
# proc_run_ctrl

Synthesisable run controller for the single-cycle processor core. It owns the core's reset and clock-enable. It sequences a parametrised reset pulse, then runs the core freely or one instruction per step request. Execution terminates on a halt indication or a cycle budget, and the controller reports cycle count and completion status. It sits between the top-level bench or board logic and `Main_Processor`, replacing fixed hand-written reset/clock sequences.

## Interface
Parameters:
- `RST_CYCLES`, 2: cycles core_reset is held after start; legal range ≥1.
- `MAX_CYCLES`, 15: cycle budget before timeout; 0 = unlimited.
- `CNT_W`, 16: width of cycle counter; must hold MAX_CYCLES.

Ports:
- `Clk`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled request to begin a run.
- `step_mode`  in  1  0 = free run, 1 = single-step.
- `step`  in  1  step request; rising edge = one instruction.
- `halt`  in  1  core halt indication, e.g. halt opcode decoded.
- `core_reset`  out  1  reset to core, active-high.
- `core_en`  out  1  core clock-enable; one instruction retires per Clk edge with core_en=1.
- `cycle_count`  out  CNT_W  enabled cycles in current or last run.
- `done`  out  1  run finished; held until restart.
- `timeout`  out  1  run ended by MAX_CYCLES budget.

## Operation
- States: IDLE, RSTSEQ, RUN, DONE. 2-bit encoded, default branch → IDLE.
- Reset values:
  - state=IDLE, cycle_count=0, done=0, timeout=0, internal rst counter=0, step_q=0.
  - Outputs: core_reset=1, core_en=0.
- `core_reset` = (state==IDLE) | (state==RSTSEQ), combinational.
- `core_en` = (state==RUN) & !halt & (!step_mode | step_rise), combinational.
  - step_rise = step & !step_q; step_q is step registered every cycle in all states.
- IDLE, start=1 → RSTSEQ:
  - Load rst counter with RST_CYCLES-1.
  - Clear cycle_count, done and timeout.
- RSTSEQ:
  - Decrement rst counter each cycle.
  - At 0 → RUN.
  - start ignored.
- RUN:
  - Each edge with core_en=1: cycle_count += 1.
  - If MAX_CYCLES≠0 and the incremented value equals MAX_CYCLES → DONE, timeout=1, done=1.
  - halt=1 sampled → DONE, done=1, timeout=0. No increment that cycle, since core_en=0, so halt and timeout cannot coincide.
  - start ignored.
- Single-step:
  - One core_en cycle per step rising edge.
  - Holding step high yields exactly one cycle.
  - Changing step_mode takes effect combinationally in the same cycle.
- DONE:
  - core_reset=0, core_en=0.
  - cycle_count, done and timeout hold.
  - start=1 → RSTSEQ, with the same clears as from IDLE.
- MAX_CYCLES=0: cycle_count saturates at 2^CNT_W-1 and never wraps. The run continues until halt.
- Reset asserted in any state → IDLE immediately, without waiting for Clk, with all reset values.

## Timing
- Start accepted at edge T: core_reset stays high through edge T+RST_CYCLES. The state is RUN after edge T+RST_CYCLES.
- Free run: the first core_en=1 cycle is the cycle after edge T+RST_CYCLES. Start-to-first-enabled-cycle latency = RST_CYCLES+1 edges.
- Step: core_en rises in the same cycle step first reads high, since step_q is still 0. It is one cycle wide.
- Completion by halt: halt seen at edge E → done=1 after E, and core_en is already 0 during the halt cycle.
- Completion by timeout: the MAX_CYCLES-th enabled cycle ends at edge E → done=timeout=1 after E. core_en=0 from E onward.
- No combinational path from start to any output. step and halt reach core_en combinationally.

## Test plan
- Default parameters, Reset pulse, then start high 1 cycle, halt=0, step_mode=0 → core_reset high 2 cycles after start, then core_en high 15 consecutive cycles. Then done=1, timeout=1, cycle_count=15.
- Same, halt raised when cycle_count=5 → core_en=0 in the halt cycle. Then done=1, timeout=0, cycle_count=5 held.
- step_mode=1, three step pulses each 4 cycles high with 3 cycles low between → exactly 3 single-cycle core_en pulses, cycle_count=3, done=0.
- Reset asserted mid-RUN at cycle_count=7, between clock edges → immediately core_reset=1, core_en=0, cycle_count=0, done=0. A subsequent start runs normally.
- start held high during RSTSEQ/RUN → no restart, count unaffected. start in DONE → cycle_count=0, done=0, timeout=0 after that edge, and the reset sequence repeats.
- MAX_CYCLES=0, CNT_W=8, free run 300 cycles, halt=0 → cycle_count saturates at 255, done=0. Raising halt then gives done=1, timeout=0.
